// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: configurable-depth control-bundle pipeline (decode -> E/M/W).
// Each stage has its own stall and flush. A stalled stage freezes every stage
// behind it, and a bubble is injected into the stage just ahead of it.
// Two saturating event counters are provided for hazard debugging.
module ctrl_pipeline #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_ctrl,
    input  logic                      in_valid,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic                      in_ready,
    output logic [STAGES*WIDTH-1:0]   out_ctrl,
    output logic [STAGES-1:0]         out_valid,
    output logic [CNT_W-1:0]          bubble_cnt,
    output logic [CNT_W-1:0]          squash_cnt
);

    logic [STAGES-1:0][WIDTH-1:0] ctrl_q;
    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0]            estall;
    logic                         stall_acc;
    logic                         bubble_ev;
    logic                         squash_ev;
    logic [CNT_W-1:0]             bubble_q;
    logic [CNT_W-1:0]             squash_q;

    // Effective stall: a stall in any later stage freezes this one too.
    always_comb begin
        estall    = '0;
        stall_acc = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stall_acc = stall_acc | stall[k];
            estall[k] = stall_acc;
        end
    end

    // Event detection: a stall bubble lands only in the stage right after the
    // oldest stalled stage, and only when that stage is not being flushed.
    always_comb begin
        bubble_ev = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            if (!flush[k] && !estall[k] && estall[k-1]) begin
                bubble_ev = 1'b1;
            end
        end
        squash_ev = |(flush & valid_q);
    end

    // Stage registers: reset, then flush, hold, load/bubble/copy in that order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            valid_q <= '0;
        end else begin
            if (flush[0]) begin
                ctrl_q[0]  <= '0;
                valid_q[0] <= 1'b0;
            end else if (!estall[0]) begin
                ctrl_q[0]  <= in_valid ? in_ctrl : '0;
                valid_q[0] <= in_valid;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (flush[k]) begin
                    ctrl_q[k]  <= '0;
                    valid_q[k] <= 1'b0;
                end else if (estall[k]) begin
                    ctrl_q[k]  <= ctrl_q[k];
                    valid_q[k] <= valid_q[k];
                end else if (estall[k-1]) begin
                    ctrl_q[k]  <= '0;
                    valid_q[k] <= 1'b0;
                end else begin
                    ctrl_q[k]  <= ctrl_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end
    end

    // Saturating debug counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
            squash_q <= '0;
        end else begin
            if (bubble_ev && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
            if (squash_ev && (squash_q != '1)) begin
                squash_q <= squash_q + CNT_W'(1);
            end
        end
    end

    assign in_ready   = ~estall[0] & ~rst;
    assign out_ctrl   = ctrl_q;
    assign out_valid  = valid_q;
    assign bubble_cnt = bubble_q;
    assign squash_cnt = squash_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Testbench for ctrl_pipeline (WIDTH=8, STAGES=3, CNT_W=16).
// Directed scenarios followed by random traffic, all compared against a
// behavioural model that reasons about the oldest stalled stage.
module tb_ctrl_pipeline;

    localparam int W  = 8;
    localparam int S  = 3;
    localparam int CW = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    in_ctrl;
    logic            in_valid;
    logic [S-1:0]    stall;
    logic [S-1:0]    flush;
    logic            in_ready;
    logic [S*W-1:0]  out_ctrl;
    logic [S-1:0]    out_valid;
    logic [CW-1:0]   bubble_cnt;
    logic [CW-1:0]   squash_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [W-1:0] m_ctrl [S];
    logic [S-1:0] m_valid;
    int           m_bub;
    int           m_sq;

    ctrl_pipeline #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_ctrl    (in_ctrl),
        .in_valid   (in_valid),
        .stall      (stall),
        .flush      (flush),
        .in_ready   (in_ready),
        .out_ctrl   (out_ctrl),
        .out_valid  (out_valid),
        .bubble_cnt (bubble_cnt),
        .squash_cnt (squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int oldest_stall();
        int s;
        s = -1;
        for (int k = 0; k < S; k++) if (stall[k]) s = k;
        return s;
    endfunction

    function automatic logic [S*W-1:0] m_packed();
        return {m_ctrl[2], m_ctrl[1], m_ctrl[0]};
    endfunction

    // One clock edge of the reference model, from the currently driven inputs.
    task automatic model_edge();
        logic [W-1:0] nc [S];
        logic [S-1:0] nv;
        int s;
        if (rst) begin
            for (int k = 0; k < S; k++) m_ctrl[k] = '0;
            m_valid = '0;
            m_bub = 0;
            m_sq  = 0;
        end else begin
            s = oldest_stall();
            if ((flush & m_valid) != '0 && m_sq < CNT_MAX) m_sq++;
            if (s >= 0 && s + 1 < S && !flush[s+1] && m_bub < CNT_MAX) m_bub++;
            for (int k = 0; k < S; k++) begin
                if (k <= s) begin
                    nc[k] = m_ctrl[k];
                    nv[k] = m_valid[k];
                end else if (s >= 0 && k == s + 1) begin
                    nc[k] = '0;
                    nv[k] = 1'b0;
                end else if (k == 0) begin
                    nc[k] = in_valid ? in_ctrl : '0;
                    nv[k] = in_valid;
                end else begin
                    nc[k] = m_ctrl[k-1];
                    nv[k] = m_valid[k-1];
                end
                if (flush[k]) begin
                    nc[k] = '0;
                    nv[k] = 1'b0;
                end
            end
            for (int k = 0; k < S; k++) m_ctrl[k] = nc[k];
            m_valid = nv;
        end
    endtask

    // Check in_ready against the driven inputs, clock once, check registered outputs.
    task automatic step();
        #1;
        check("in_ready", 32'(in_ready), 32'(!rst && oldest_stall() < 0));
        @(posedge clk);
        model_edge();
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_ctrl", 32'(out_ctrl), 32'(m_packed()));
        check("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
        check("squash_cnt", 32'(squash_cnt), 32'(m_sq));
    endtask

    task automatic drive(input logic r, input logic v, input logic [W-1:0] c,
                         input logic [S-1:0] st, input logic [S-1:0] fl);
        rst = r; in_valid = v; in_ctrl = c; stall = st; flush = fl;
    endtask

    initial begin
        for (int k = 0; k < S; k++) m_ctrl[k] = '0;
        m_valid = '0;
        m_bub = 0;
        m_sq  = 0;

        // 1. reset with random side inputs
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom), W'($urandom), S'($urandom), S'($urandom));
            step();
        end
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ctrl", 32'(out_ctrl), 32'h0);
        check("rst_bub", 32'(bubble_cnt), 32'h0);

        // 2. free flow
        drive(1'b0, 1'b1, 8'hA1, 3'b000, 3'b000); step();
        check("flow_v1", 32'(out_valid), 32'b001);
        drive(1'b0, 1'b1, 8'hA2, 3'b000, 3'b000); step();
        check("flow_v2", 32'(out_valid), 32'b011);
        drive(1'b0, 1'b1, 8'hA3, 3'b000, 3'b000); step();
        check("flow_v3", 32'(out_valid), 32'b111);
        check("flow_ctrl", 32'(out_ctrl), 32'hA1A2A3);

        // 3. mid-pipe stall for two cycles, then release
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 8'h00, 3'b010, 3'b000);
            step();
            check("stall_v", 32'(out_valid), 32'b011);
            check("stall_ctrl", 32'(out_ctrl), 32'h00A2A3);
        end
        check("stall_bub", 32'(bubble_cnt), 32'd2);
        drive(1'b0, 1'b1, 8'hA4, 3'b000, 3'b000); step();
        check("release_ctrl", 32'(out_ctrl), 32'hA2A3A4);

        // 4. flush beats stall on stage 0
        drive(1'b1, 1'b0, 8'h00, 3'b000, 3'b000); step();
        drive(1'b0, 1'b1, 8'h5C, 3'b000, 3'b000); step();
        drive(1'b0, 1'b1, 8'h77, 3'b001, 3'b001); step();
        check("fbs_valid", 32'(out_valid), 32'b000);
        check("fbs_sq", 32'(squash_cnt), 32'd1);
        check("fbs_bub", 32'(bubble_cnt), 32'd1);

        // 5. invalid input is loaded as a zero bundle
        drive(1'b0, 1'b0, 8'hFF, 3'b000, 3'b000); step();
        check("inv_ctrl0", 32'(out_ctrl[W-1:0]), 32'h00);
        check("inv_valid0", 32'(out_valid[0]), 32'h0);
        check("inv_sq", 32'(squash_cnt), 32'd1);

        // random traffic with occasional stalls, flushes and resets
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0),
                  1'($urandom),
                  W'($urandom),
                  S'(($urandom_range(0, 3) == 0) ? $urandom : 0),
                  S'(($urandom_range(0, 4) == 0) ? $urandom : 0));
            step();
        end

        // 6. saturation of bubble_cnt, then reset mid-stall
        drive(1'b1, 1'b0, 8'h00, 3'b000, 3'b000); step();
        drive(1'b0, 1'b1, 8'h11, 3'b000, 3'b000); step();
        for (int i = 0; i < 65540; i++) begin
            drive(1'b0, 1'($urandom), W'($urandom), 3'b010, 3'b000);
            step();
        end
        check("sat_bub", 32'(bubble_cnt), 32'hFFFF);
        drive(1'b1, 1'b1, 8'h33, 3'b010, 3'b100); step();
        check("sat_rst_bub", 32'(bubble_cnt), 32'h0);
        check("sat_rst_valid", 32'(out_valid), 32'h0);
        check("sat_rst_ctrl", 32'(out_ctrl), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
